// File: rtl/writeback_stage.sv
// MIPS write-back stage: MEM/WB register, result select, MOVZ/MOVN resolve, HI/LO and retire count.
// Latency: result presented from the accept edge until its commit edge; HI/LO/count visible one cycle after commit.
// Backpressure: InReady = ~OutValid | OutReady, so a stalled full entry blocks upstream with no bubble on release.
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [DATA_WIDTH-1:0]   MemoryReadData,
  input  logic [DATA_WIDTH-1:0]   ALUResult,
  input  logic                    Zero,
  input  logic [2*DATA_WIDTH-1:0] HiLoData,
  input  logic [ADDR_WIDTH-1:0]   InWriteReg,
  input  logic                    RegWrite,
  input  logic                    MemToReg,
  input  logic                    HiOrLo,
  input  logic                    HiToReg,
  input  logic                    DontMove,
  input  logic                    MoveOnNotZero,
  input  logic                    HiWrite,
  input  logic                    LoWrite,
  input  logic                    OutReady,
  output logic                    OutValid,
  output logic [DATA_WIDTH-1:0]   WriteData,
  output logic [ADDR_WIDTH-1:0]   WriteReg,
  output logic                    WriteEnable,
  output logic [DATA_WIDTH-1:0]   HiOut,
  output logic [DATA_WIDTH-1:0]   LoOut,
  output logic [CNT_WIDTH-1:0]    RetireCount
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   memData;
    logic [DATA_WIDTH-1:0]   aluResult;
    logic                    zero;
    logic [2*DATA_WIDTH-1:0] hiLoData;
    logic [ADDR_WIDTH-1:0]   writeReg;
    logic                    regWrite;
    logic                    memToReg;
    logic                    hiOrLo;
    logic                    hiToReg;
    logic                    dontMove;
    logic                    moveOnNotZero;
    logic                    hiWrite;
    logic                    loWrite;
  } wbFields_t;

  wbFields_t             wbReg;
  wbFields_t             wbIn;
  logic                  validReg;
  logic [DATA_WIDTH-1:0] hiReg;
  logic [DATA_WIDTH-1:0] loReg;
  logic [CNT_WIDTH-1:0]  retireReg;
  logic                  accept;
  logic                  commit;
  logic                  move;
  logic [DATA_WIDTH-1:0] memSel;
  logic [DATA_WIDTH-1:0] hiLoSel;

  assign wbIn = '{
    memData:       MemoryReadData,
    aluResult:     ALUResult,
    zero:          Zero,
    hiLoData:      HiLoData,
    writeReg:      InWriteReg,
    regWrite:      RegWrite,
    memToReg:      MemToReg,
    hiOrLo:        HiOrLo,
    hiToReg:       HiToReg,
    dontMove:      DontMove,
    moveOnNotZero: MoveOnNotZero,
    hiWrite:       HiWrite,
    loWrite:       LoWrite
  };

  // A full entry only blocks upstream when downstream refuses it.
  assign InReady = ~validReg | OutReady;
  assign accept  = InValid & InReady;
  assign commit  = validReg & OutReady;

  // MEM/WB register: accept overwrites (also when committing the old entry the same cycle).
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      validReg <= 1'b0;
      wbReg    <= '0;
    end else if (accept) begin
      validReg <= 1'b1;
      wbReg    <= wbIn;
    end else if (commit) begin
      validReg <= 1'b0;
    end
  end

  // Architectural HI/LO and retire counter change only when an instruction commits.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      hiReg     <= '0;
      loReg     <= '0;
      retireReg <= '0;
    end else if (commit) begin
      if (wbReg.hiWrite) hiReg <= wbReg.hiLoData[2*DATA_WIDTH-1:DATA_WIDTH];
      if (wbReg.loWrite) loReg <= wbReg.hiLoData[DATA_WIDTH-1:0];
      retireReg <= retireReg + CNT_WIDTH'(1);
    end
  end

  // Reads of HI/LO use the committed registers, so an instruction never sees its own HI/LO write.
  assign memSel  = wbReg.memToReg ? wbReg.memData : wbReg.aluResult;
  assign hiLoSel = wbReg.hiOrLo ? hiReg : loReg;
  assign move    = wbReg.dontMove | (wbReg.moveOnNotZero ? ~wbReg.zero : wbReg.zero);

  assign OutValid    = validReg;
  assign WriteData   = wbReg.hiToReg ? hiLoSel : memSel;
  assign WriteReg    = wbReg.writeReg;
  assign WriteEnable = commit & wbReg.regWrite & move & (wbReg.writeReg != '0);
  assign HiOut       = hiReg;
  assign LoOut       = loReg;
  assign RetireCount = retireReg;

endmodule
